// File: rtl/plot_framebuffer.sv
// plot_framebuffer: buffers pixel-plot requests in a FIFO and commits them to a
// single-port 160x120x3 frame memory that is also scanned out in raster order.
//   iClock, iResetn            clock, synchronous active-low reset
//   iX, iY, iColour, iPlot     plot request (accepted when oReady=1)
//   oReady, oBusy              FIFO not full / FIFO non-empty
//   oOverflow, oRangeErr       sticky error flags (cleared by reset only)
//   iScanEn                    enable raster scan-out
//   oScanX, oScanY, oScanColour, oScanValid, oFrameStart   scan-out pixel stream
module plot_framebuffer #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic [7:0] iX,
    input  logic [6:0] iY,
    input  logic [2:0] iColour,
    input  logic       iPlot,
    output logic       oReady,
    output logic       oBusy,
    output logic       oOverflow,
    output logic       oRangeErr,
    input  logic       iScanEn,
    output logic [7:0] oScanX,
    output logic [6:0] oScanY,
    output logic [2:0] oScanColour,
    output logic       oScanValid,
    output logic       oFrameStart
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] X_LAST = 8'(X_SCREEN_PIXELS - 1);
    localparam logic [6:0] Y_LAST = 7'(Y_SCREEN_PIXELS - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    logic [2:0] mem [X_SCREEN_PIXELS * Y_SCREEN_PIXELS];
    logic [7:0] fx [FIFO_DEPTH];
    logic [6:0] fy [FIFO_DEPTH];
    logic [2:0] fc [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic phase;
    logic [7:0] sx;
    logic [6:0] sy;
    logic push, rd_slot, pop, head_ok, wen;
    logic [14:0] waddr, raddr;

    assign oReady = count != FULL;
    assign oBusy = count != '0;
    assign push = iPlot && oReady;
    assign rd_slot = !phase && iScanEn;
    assign pop = !rd_slot && oBusy;
    // out-of-range entries are still popped, they just never reach memory
    assign head_ok = fx[rp] <= X_LAST && fy[rp] <= Y_LAST;
    assign wen = pop && head_ok && iResetn;
    assign waddr = 15'(fy[rp]) * 15'(X_SCREEN_PIXELS) + 15'(fx[rp]);
    assign raddr = 15'(sy) * 15'(X_SCREEN_PIXELS) + 15'(sx);

    always_ff @(posedge iClock) begin
        if (wen)
            mem[waddr] <= fc[rp];
    end

    always_ff @(posedge iClock) begin
        if (push) begin
            fx[wp] <= iX;
            fy[wp] <= iY;
            fc[wp] <= iColour;
        end
    end

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            oOverflow <= 1'b0;
            oRangeErr <= 1'b0;
        end else begin
            wp <= push ? wp + 1'b1 : wp;
            rp <= pop ? rp + 1'b1 : rp;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            oOverflow <= oOverflow || (iPlot && !oReady);
            oRangeErr <= oRangeErr || (push && (iX > X_LAST || iY > Y_LAST));
        end
    end

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            phase <= 1'b0;
            sx <= '0;
            sy <= '0;
            oScanX <= '0;
            oScanY <= '0;
            oScanColour <= '0;
            oScanValid <= 1'b0;
            oFrameStart <= 1'b0;
        end else begin
            phase <= !phase;
            oScanValid <= rd_slot;
            oFrameStart <= rd_slot && sx == '0 && sy == '0;
            if (rd_slot) begin
                oScanX <= sx;
                oScanY <= sy;
                oScanColour <= mem[raddr];
                sx <= sx == X_LAST ? '0 : sx + 1'b1;
                sy <= sx != X_LAST ? sy : (sy == Y_LAST ? '0 : sy + 1'b1);
            end
        end
    end
endmodule

// File: tb/tb_plot_framebuffer.sv
// tb_plot_framebuffer: random and directed stimulus against a queue/array model of the framebuffer.
module tb_plot_framebuffer;
    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] px = '0;
    logic [6:0] py = '0;
    logic [2:0] pc = '0;
    logic       plot = 1'b0;
    logic       scan = 1'b0;
    logic       oReady, oBusy, oOverflow, oRangeErr, oScanValid, oFrameStart;
    logic [7:0] oScanX;
    logic [6:0] oScanY;
    logic [2:0] oScanColour;

    plot_framebuffer dut (
        .iClock(clk), .iResetn(rstn), .iX(px), .iY(py), .iColour(pc), .iPlot(plot),
        .oReady(oReady), .oBusy(oBusy), .oOverflow(oOverflow), .oRangeErr(oRangeErr),
        .iScanEn(scan), .oScanX(oScanX), .oScanY(oScanY), .oScanColour(oScanColour),
        .oScanValid(oScanValid), .oFrameStart(oFrameStart)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct { int x; int y; int c; } req_t;
    req_t mq[$];
    int mmem [N];
    bit known [N];
    bit ph, live = 0;
    int pos;
    int m_valid, m_fs, m_x, m_y, m_c, m_ck, m_ovf, m_rerr;

    always @(posedge clk) begin
        req_t e;
        bit rd, rdy;
        if (!rstn) begin
            mq.delete();
            ph = 0; pos = 0;
            m_valid = 0; m_fs = 0; m_x = 0; m_y = 0; m_c = 0; m_ck = 1;
            m_ovf = 0; m_rerr = 0;
        end else begin
            rd = !ph && scan;
            rdy = mq.size() < DEPTH;
            m_valid = rd;
            m_fs = rd && pos == 0;
            if (rd) begin
                m_x = pos % W;
                m_y = pos / W;
                m_ck = known[pos];
                m_c = mmem[pos];
                pos = (pos + 1) % N;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.x < W && e.y < H) begin
                    mmem[e.y * W + e.x] = e.c;
                    known[e.y * W + e.x] = 1;
                end
            end
            if (plot) begin
                if (rdy) begin
                    mq.push_back('{int'(px), int'(py), int'(pc)});
                    if (px >= W || py >= H) m_rerr = 1;
                end else m_ovf = 1;
            end
            ph = !ph;
        end
        live = 1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("ready", oReady, mq.size() < DEPTH);
            chk("busy", oBusy, mq.size() > 0);
            chk("valid", oScanValid, m_valid);
            chk("framestart", oFrameStart, m_fs);
            chk("overflow", oOverflow, m_ovf);
            chk("rangeerr", oRangeErr, m_rerr);
            chk("scanx", oScanX, m_x);
            chk("scany", oScanY, m_y);
            if (m_ck) chk("colour", oScanColour, m_c);
        end
    end

    task automatic nx();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 0;
        plot = 0;
        nx();
        rstn = 1;
    endtask

    task automatic put(input int x, input int y, input int c);
        px = 8'(x); py = 7'(y); pc = 3'(c); plot = 1;
        nx();
        plot = 0;
    endtask

    task automatic wait_pix(input int x, input int y, input int bound, input string nm);
        int n = 0;
        bit found = 0;
        while (!found && n < bound) begin
            nx();
            n++;
            found = oScanValid && oScanX == 8'(x) && oScanY == 7'(y);
        end
        chk(nm, found, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, lastn, errs, col00, collast, last_x;
        bit found;
        for (int i = 0; i < N; i++) known[i] = 0;
        #1;
        nx(); nx();
        chk("rst_valid", oScanValid, 0);
        chk("rst_x", oScanX, 0);
        chk("rst_colour", oScanColour, 0);
        chk("rst_busy", oBusy, 0);
        rstn = 1;

        // single plot with scan off drains in one cycle
        scan = 0;
        px = 8'd5; py = 7'd3; pc = 3'd6; plot = 1;
        nx();
        plot = 0;
        chk("t1_busy_hi", oBusy, 1);
        nx();
        chk("t1_busy_lo", oBusy, 0);
        for (int i = 0; i < 8; i++) put(60 + i, 0, 1);
        repeat (3) nx();
        do_reset();
        scan = 1;
        wait_pix(5, 3, 3000, "t1_found");
        chk("t1_colour", oScanColour, 6);

        // back-to-back plots with scanning: FIFO fills and refuses
        do_reset();
        chk("t2_ovf_clear", oOverflow, 0);
        for (int i = 0; i < 10; i++) begin
            px = 8'(20 + i); py = 7'd10; pc = 3'(i); plot = 1;
            nx();
        end
        plot = 0;
        chk("t2_ovf_set", oOverflow, 1);
        repeat (12) nx();
        chk("t2_drained", oBusy, 0);

        // out-of-range plots are flagged and leave the corners intact
        scan = 0;
        do_reset();
        put(0, 0, 3);
        put(W - 1, H - 1, 5);
        put(W, 0, 7);
        put(0, H, 7);
        repeat (4) nx();
        chk("t3_rangeerr", oRangeErr, 1);
        chk("t3_ovf", oOverflow, 0);

        // full frame scan from reset
        scan = 1;
        do_reset();
        k = 0; n = 0; lastn = 0; errs = 0; col00 = -1; collast = -1;
        while (k < N + 1 && n < 2 * N + 100) begin
            nx();
            n++;
            if (oScanValid) begin
                if (oScanX != 8'(k % W) || oScanY != 7'((k / W) % H)) errs++;
                if (oFrameStart != (k == 0 || k == N)) errs++;
                if (k > 0 && n - lastn != 2) errs++;
                if (k == 0) col00 = oScanColour;
                if (k == N - 1) collast = oScanColour;
                lastn = n;
                k++;
            end else if (oFrameStart) errs++;
        end
        chk("t3_frame_pixels", k, N + 1);
        chk("t3_frame_errs", errs, 0);
        chk("t3_first_valid", n - 2 * N, 1);
        chk("t3_col00", col00, 3);
        chk("t3_collast", collast, 5);

        // pause and resume the scan mid-frame
        wait_pix(10, 2, 2000, "t4_found");
        scan = 0;
        repeat (7) nx();
        scan = 1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            nx();
            found = oScanValid;
        end
        chk("t4_resumed", found, 1);
        chk("t4_x", oScanX, 11);
        chk("t4_y", oScanY, 2);

        // reset with pending plots and the scan part way through the frame
        do_reset();
        wait_pix(39, 50, 20000, "t5_found");
        put(200, 5, 2);
        last_x = 60;
        for (int i = 0; i < 8 && mq.size() < 3; i++) begin
            last_x = 60 + i;
            px = 8'(last_x); py = 7'd0; pc = 3'd4; plot = 1;
            nx();
        end
        plot = 0;
        chk("t5_busy", oBusy, 1);
        chk("t5_rerr", oRangeErr, 1);
        rstn = 0;
        nx();
        rstn = 1;
        chk("t5_busy_clr", oBusy, 0);
        chk("t5_rerr_clr", oRangeErr, 0);
        chk("t5_ovf_clr", oOverflow, 0);
        chk("t5_valid_clr", oScanValid, 0);
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            nx();
            found = oScanValid;
        end
        chk("t5_first", found, 1);
        chk("t5_first_x", oScanX, 0);
        chk("t5_first_y", oScanY, 0);
        chk("t5_first_fs", oFrameStart, 1);
        wait_pix(last_x, 0, 400, "t5_pending_found");
        chk("t5_pending_unwritten", oScanColour, 1);

        // randomized traffic concentrated in the first rows so reads revisit writes
        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom % 800) != 0;
            scan = ($urandom % 4) != 0;
            plot = ($urandom % 3) == 0;
            px = ($urandom % 8 == 0) ? 8'(150 + $urandom % 20) : 8'($urandom % W);
            py = ($urandom % 10 == 0) ? 7'(115 + $urandom % 13) : 7'($urandom % 10);
            pc = 3'($urandom);
            nx();
        end
        rstn = 1;
        plot = 0;
        nx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
